// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if: PS/2 line inputs plus scan-code and cursor/colour outputs
interface ps2_keyboard_rx_if;
   logic       iPS2_CLK;
   logic       iPS2_DATA;
   logic [7:0] oScanCode;
   logic       oScanValid;
   logic       oRxError;
   logic [3:0] oColor;
   logic [7:0] oXRedCounter;
   logic [7:0] oYRedCounter;
   modport master (output iPS2_CLK, iPS2_DATA,
                   input oScanCode, oScanValid, oRxError, oColor, oXRedCounter, oYRedCounter);
   modport slave (input iPS2_CLK, iPS2_DATA,
                  output oScanCode, oScanValid, oRxError, oColor, oXRedCounter, oYRedCounter);
endinterface

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 frame receiver driving the red-square position and colour
module ps2_keyboard_rx #(
   parameter int         TIMEOUT_CYCLES = 100000,
   parameter logic [7:0] X_MAX          = 8'd251,
   parameter logic [7:0] Y_MAX          = 8'd251,
   parameter logic [7:0] STEP           = 8'd4
) (
   input logic              Clock,
   input logic              Reset,
   ps2_keyboard_rx_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [2:0]    clkSync;
   logic [1:0]    dataSync;
   logic [1:0]    state;
   logic [2:0]    bitCnt;
   logic [7:0]    shiftReg;
   logic          parityBit;
   logic [TW-1:0] timeoutCnt;
   logic          breakFlag, extFlag;
   logic          fall, din, good;
   logic [8:0]    xInc, xDec, yInc, yDec;
   assign fall = clkSync[2] & ~clkSync[1];
   assign din  = dataSync[1];
   assign good = din & (^{shiftReg, parityBit});
   // Bit 8 of the 9-bit sums flags overflow past 255 or borrow below 0
   assign xInc = {1'b0, bus.oXRedCounter} + {1'b0, STEP};
   assign xDec = {1'b0, bus.oXRedCounter} - {1'b0, STEP};
   assign yInc = {1'b0, bus.oYRedCounter} + {1'b0, STEP};
   assign yDec = {1'b0, bus.oYRedCounter} - {1'b0, STEP};
   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) begin
         clkSync  <= '0;
         dataSync <= '0;
      end else begin
         clkSync  <= {clkSync[1:0], bus.iPS2_CLK};
         dataSync <= {dataSync[0], bus.iPS2_DATA};
      end
   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) begin
         state          <= IDLE;
         bitCnt         <= '0;
         shiftReg       <= '0;
         parityBit      <= 1'b0;
         timeoutCnt     <= '0;
         bus.oScanCode  <= '0;
         bus.oScanValid <= 1'b0;
         bus.oRxError   <= 1'b0;
      end else begin
         bus.oScanValid <= 1'b0;
         bus.oRxError   <= 1'b0;
         timeoutCnt     <= (state == IDLE || fall) ? '0 : timeoutCnt + 1'b1;
         if (state != IDLE && !fall && timeoutCnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state      <= IDLE;
            timeoutCnt <= '0;
         end else if (fall) begin
            case (state)
               IDLE: begin
                  state  <= din ? IDLE : DATA;
                  bitCnt <= '0;
               end
               DATA: begin
                  shiftReg <= {din, shiftReg[7:1]};
                  bitCnt   <= bitCnt + 1'b1;
                  state    <= (bitCnt == 3'd7) ? PARITY : DATA;
               end
               PARITY: begin
                  parityBit <= din;
                  state     <= STOP;
               end
               default: begin
                  state          <= IDLE;
                  bus.oScanValid <= good;
                  bus.oRxError   <= ~good;
                  if (good) bus.oScanCode <= shiftReg;
               end
            endcase
         end
      end
   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) begin
         breakFlag        <= 1'b0;
         extFlag          <= 1'b0;
         bus.oColor       <= '0;
         bus.oXRedCounter <= '0;
         bus.oYRedCounter <= '0;
      end else if (bus.oScanValid) begin
         if (bus.oScanCode == 8'hE0) extFlag <= 1'b1;
         else if (bus.oScanCode == 8'hF0) breakFlag <= 1'b1;
         else if (breakFlag) begin
            breakFlag <= 1'b0;
            extFlag   <= 1'b0;
         end else begin
            extFlag <= 1'b0;
            if (!extFlag) begin
               if (bus.oScanCode == 8'h1D) bus.oYRedCounter <= yDec[8] ? '0 : yDec[7:0];
               if (bus.oScanCode == 8'h1B) bus.oYRedCounter <= (yInc > {1'b0, Y_MAX}) ? Y_MAX : yInc[7:0];
               if (bus.oScanCode == 8'h1C) bus.oXRedCounter <= xDec[8] ? '0 : xDec[7:0];
               if (bus.oScanCode == 8'h23) bus.oXRedCounter <= (xInc > {1'b0, X_MAX}) ? X_MAX : xInc[7:0];
               if (bus.oScanCode == 8'h2D) bus.oColor <= bus.oColor + 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: randomized PS/2 frames checked against a key-action model
module tb_ps2_keyboard_rx;
   localparam int TO  = 400;
   localparam int H   = 8;
   localparam int GAP = 20;
   logic Clock = 1'b0;
   logic Reset = 1'b0;
   int   assertCnt = 0, failCnt = 0;
   int   validCnt = 0, errCnt = 0;
   int   mValid = 0, mErr = 0, mCode = 0, mX = 0, mY = 0, mColor = 0;
   bit   mExt = 0, mBrk = 0;
   ps2_keyboard_rx_if bus ();
   ps2_keyboard_rx #(.TIMEOUT_CYCLES(TO)) dut (.Clock(Clock), .Reset(Reset), .bus(bus.slave));
   always #5 Clock = ~Clock;
   always @(negedge Clock) begin
      if (bus.oScanValid) validCnt++;
      if (bus.oRxError) errCnt++;
   end
   task automatic checkEq(input string tag, input int actual, input int expected);
      assertCnt++;
      if (actual != expected) begin
         failCnt++;
         $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask
   task automatic waitCycles(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask
   task automatic checkAll(input string tag);
      checkEq({tag, ".valid"}, validCnt, mValid);
      checkEq({tag, ".err"}, errCnt, mErr);
      checkEq({tag, ".code"}, int'(bus.oScanCode), mCode);
      checkEq({tag, ".x"}, int'(bus.oXRedCounter), mX);
      checkEq({tag, ".y"}, int'(bus.oYRedCounter), mY);
      checkEq({tag, ".color"}, int'(bus.oColor), mColor);
   endtask
   task automatic modelReset();
      mCode = 0; mX = 0; mY = 0; mColor = 0; mExt = 0; mBrk = 0;
   endtask
   task automatic applyByte(input int b);
      if (b == 'hE0) mExt = 1;
      else if (b == 'hF0) mBrk = 1;
      else if (mBrk) begin
         mBrk = 0;
         mExt = 0;
      end else begin
         if (!mExt) begin
            if (b == 'h1D) mY = (mY - 4 < 0) ? 0 : mY - 4;
            if (b == 'h1B) mY = (mY + 4 > 251) ? 251 : mY + 4;
            if (b == 'h1C) mX = (mX - 4 < 0) ? 0 : mX - 4;
            if (b == 'h23) mX = (mX + 4 > 251) ? 251 : mX + 4;
            if (b == 'h2D) mColor = (mColor + 1) % 16;
         end
         mExt = 0;
      end
   endtask
   task automatic sendBits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         bus.iPS2_DATA = f[i];
         waitCycles(H);
         bus.iPS2_CLK = 1'b0;
         waitCycles(H);
         bus.iPS2_CLK = 1'b1;
      end
      bus.iPS2_DATA = 1'b1;
   endtask
   task automatic sendFrame(input logic [7:0] b, input bit badPar, input bit badStop);
      sendBits({~badStop, (~^b) ^ badPar, b, 1'b0}, 11);
      if (badPar || badStop) mErr++;
      else begin
         mValid++;
         mCode = b;
         applyByte(b);
      end
      waitCycles(GAP);
   endtask
   initial begin
      logic [7:0] b;
      int k;
      bus.iPS2_CLK  = 1'b1;
      bus.iPS2_DATA = 1'b1;
      waitCycles(5);
      Reset = 1'b1;
      waitCycles(1000);
      checkAll("reset");
      sendFrame(8'h23, 0, 0); checkAll("make_d");
      sendFrame(8'h23, 1, 0); checkAll("bad_parity");
      sendFrame(8'h23, 0, 1); checkAll("bad_stop");
      sendFrame(8'hF0, 0, 0); checkAll("break");
      sendFrame(8'h23, 0, 0); checkAll("release_d");
      sendFrame(8'h2D, 0, 0); checkAll("color");
      sendFrame(8'hE0, 0, 0); checkAll("ext");
      sendFrame(8'h1D, 0, 0); checkAll("ext_w");
      sendFrame(8'h1D, 0, 0); checkAll("w_at_0");
      while (mX < 248) sendFrame(8'h23, 0, 0);
      checkAll("x_248");
      sendFrame(8'h23, 0, 0); checkAll("x_sat1");
      sendFrame(8'h23, 0, 0); checkAll("x_sat2");
      sendBits(11'b000_0000_1010, 4);
      waitCycles(TO + 10);
      checkAll("timeout");
      sendFrame(8'h1B, 0, 0); checkAll("after_timeout");
      sendBits(11'b000_0000_1010, 4);
      waitCycles(3);
      Reset = 1'b0;
      waitCycles(3);
      Reset = 1'b1;
      modelReset();
      waitCycles(10);
      checkAll("mid_reset");
      sendFrame(8'h1B, 0, 0); checkAll("after_reset");
      for (int i = 0; i < 100; i++) begin
         k = $urandom_range(0, 19);
         b = (k < 10) ? 8'(k % 5 == 0 ? 'h1D : k % 5 == 1 ? 'h1B : k % 5 == 2 ? 'h1C : k % 5 == 3 ? 'h23 : 'h2D) :
             (k < 13) ? 8'hE0 : (k < 16) ? 8'hF0 : 8'($urandom_range(0, 255));
         k = $urandom_range(0, 9);
         sendFrame(b, k == 0, k == 1);
         checkAll("rand");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end
endmodule
